// File: rtl/arbitro_ula_logica.sv
// Round-robin arbiter and sequencer for the shared bitwise logic unit.
// Two requesters; each operation takes load, execute and deliver cycles.
module arbitro_ula_logica #(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [1:0]   op0,
  input  logic [1:0]   op1,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic [N-1:0] resultado,
  output logic         ocupado,
  output logic         dono,
  output logic [7:0]   total
);

  typedef enum logic [1:0] {
    OCIOSO,
    CARREGA,
    EXECUTA,
    ENTREGA
  } estado_t;

  estado_t      estado_q, estado_d;
  logic         dono_q, dono_d;
  logic         ultimo_q, ultimo_d;
  logic [1:0]   op_q, op_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] res_q, res_d;
  logic [7:0]   total_q, total_d;
  logic         ack0_q, ack0_d;
  logic         ack1_q, ack1_d;
  logic         ocup_q, ocup_d;

  function automatic logic [N-1:0] aplica(
    input logic [1:0]   op,
    input logic [N-1:0] a,
    input logic [N-1:0] b
  );
    logic [N-1:0] r;
    unique case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  always_comb begin
    estado_d = estado_q;
    dono_d   = dono_q;
    ultimo_d = ultimo_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    total_d  = total_q;
    unique case (estado_q)
      OCIOSO: begin
        if (req0 || req1) begin
          estado_d = CARREGA;
          // On a tie the requester not served last wins.
          if (req0 && req1) dono_d = ~ultimo_q;
          else              dono_d = req1;
        end
      end
      CARREGA: begin
        op_d     = dono_q ? op1 : op0;
        a_d      = dono_q ? a1  : a0;
        b_d      = dono_q ? b1  : b0;
        estado_d = EXECUTA;
      end
      EXECUTA: begin
        res_d    = aplica(op_q, a_q, b_q);
        estado_d = ENTREGA;
      end
      ENTREGA: begin
        ultimo_d = dono_q;
        total_d  = total_q + 8'd1;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
    ack0_d = (estado_d == ENTREGA) && !dono_d;
    ack1_d = (estado_d == ENTREGA) &&  dono_d;
    ocup_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q <= OCIOSO;
      dono_q   <= 1'b0;
      ultimo_q <= 1'b1;
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      total_q  <= 8'd0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      ocup_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      dono_q   <= dono_d;
      ultimo_q <= ultimo_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      total_q  <= total_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      ocup_q   <= ocup_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign resultado = res_q;
  assign ocupado   = ocup_q;
  assign dono      = dono_q;
  assign total     = total_q;

endmodule

// File: doc/arbitro_ula_logica.md
# arbitro_ula_logica

Two-requester arbiter and sequencer for the processor's shared bitwise logic unit (AND, OR, XOR, NOT). Each requester presents an operation and operands under a request/acknowledge handshake. The block picks one requester by round-robin, latches its operands, runs the operation through a registered datapath, and returns the result with a one-cycle acknowledge. It sits between the instruction-execute stage and the debug/test port, which share the same logic unit.

## Interface
- `N`, default 8: operand and result width in bits.

- `Clock`, in, 1: single clock; all state updates on the rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `req0`, `req1`, in, 1: request from requester 0 and requester 1. Held high until the matching ack.
- `op0`, `op1`, in, 2: operation code. 00 = AND, 01 = OR, 10 = XOR, 11 = NOT of `a` (`b` ignored).
- `a0`, `b0`, `a1`, `b1`, in, N: operands, which must be stable while the matching req is high.
- `ack0`, `ack1`, out, 1: one-cycle pulse; `resultado` is valid for that requester.
- `resultado`, out, N: registered result; holds its value until the next delivery.
- `ocupado`, out, 1: high in every state except OCIOSO.
- `dono`, out, 1: index of the requester currently or last served.
- `total`, out, 8: count of completed operations; wraps from 255 to 0.

## Operation
- FSM states: OCIOSO, CARREGA, EXECUTA, ENTREGA.
- **OCIOSO**
  - No request: stay in OCIOSO.
  - Exactly one req high: grant that requester and go to CARREGA.
  - Both req high: grant the requester not equal to register `ultimo`.
  - On grant, set `dono` to the granted index.
- **CARREGA:** latch the `op`, `a` and `b` of `dono` into internal registers; go to EXECUTA.
- **EXECUTA:** compute the operation on the latched values into `resultado`; go to ENTREGA.
- **ENTREGA**
  - Assert `ack[dono]` for this cycle only.
  - Update `ultimo` to `dono`.
  - Increment `total` modulo 256.
  - Go to OCIOSO.
- **Arithmetic:** purely bitwise, N bits wide, with no carry. NOT produces `~a`.
- **Operand sampling:** operands are sampled only in CARREGA. Operand or op changes after that cycle do not affect the result.
- **Req dropped mid-operation** (protocol violation): the operation still completes and the ack still pulses.
- **Req still high in the OCIOSO cycle after its ack:** treated as a new request.
- **Never both acks:** `ack0` and `ack1` are never high in the same cycle.
- **Reset state** (applied at any clock edge with `Reset` high, including mid-operation):
  - State = OCIOSO.
  - `ack0` = `ack1` = 0.
  - `resultado` = 0.
  - `ocupado` = 0.
  - `dono` = 0.
  - `ultimo` = 1, so requester 0 wins the first tie.
  - `total` = 0.
- **Reset mid-operation:** the in-flight operation is aborted with no ack and no count.
- **Reset priority:** `Reset` overrides every other input in the same cycle.

## Timing
- Cycle numbering: the OCIOSO cycle in which the req is sampled is cycle 0.
  - Cycle 1: CARREGA.
  - Cycle 2: EXECUTA.
  - Cycle 3: ENTREGA.
- **Latency:** ack and valid `resultado` in cycle 3, i.e. 3 cycles from request sampled to ack.
- **`resultado` update:** changes at the edge entering ENTREGA, and only then.
- **Back-to-back service:** minimum 4 cycles per operation, because one OCIOSO cycle always separates deliveries.
- **Continuous requests from both sides:** acks alternate between requesters every 4 cycles.
- **`total` timing:** increments at the edge leaving ENTREGA, so it is visible from the cycle after the ack.
- **Output registration:** all outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `Reset` for 2 cycles with req1=1 → all outputs 0 and no ack during reset; after release, `dono` goes to 1 on the grant.
- **Single AND:** req0, op0=00, a0=F0, b0=3C (hex) → ack0 in cycle 3, `resultado`=30, `total`=1, `ack1` never high.
- **Tie after reset:**
  - Stimulus: req0 with OR 0F/F0, and req1 with XOR AA/FF, both raised in the same cycle.
  - Requester 0 is served first: ack0 in cycle 3, `resultado`=FF.
  - Requester 1 follows: ack1 in cycle 7, `resultado`=55.
- **Fairness:** both reqs held high continuously for 16 cycles → acks in the order 0, 1, 0, 1, spaced 4 cycles apart; `ocupado` low only in the OCIOSO cycles.
- **Reset mid-operation:** pulse `Reset` during EXECUTA → no ack, `total`=0, `resultado`=0, and the next req is served normally with full latency.
- **NOT and counter wrap:**
  - NOT with a1=5A, b1=FF → `resultado`=A5.
  - 256 completed operations → `total` returns to 0.
  - An operand changed during EXECUTA → result unaffected.
